// File: rtl/mem_access_unit_pkg.sv
// Shared CPU definitions for the MEM stage: writeback select
// encodings, memory-access FSM states and the writeback mux.
package mem_access_unit_pkg;

    localparam logic [1:0] WESL_ALU  = 2'b00;
    localparam logic [1:0] WESL_LOAD = 2'b01;
    localparam logic [1:0] WESL_PC4  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mau_state_e;

    function automatic logic [31:0] wb_select(
        input logic [1:0]  wesl,
        input logic [31:0] alu,
        input logic [31:0] pc4,
        input logic [31:0] ld
    );
        case (wesl)
            WESL_LOAD: wb_select = ld;
            WESL_PC4:  wb_select = pc4;
            default:   wb_select = alu;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_mem_wb.sv
// MEM/WB pipeline register with the writeback data mux.
// A stalled edge injects a bubble and keeps the last wr/wd.
module mem_wb_reg
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        mem_valid_i,
    input  logic        mem_we_i,
    input  logic [4:0]  mem_wr_i,
    input  logic [1:0]  mem_rf_wesl_i,
    input  logic [31:0] mem_aluC_i,
    input  logic [31:0] mem_pc4_i,
    input  logic [31:0] ld_data_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_wr_o,
    output logic [31:0] wb_wd_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_o <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_wr_o    <= 5'd0;
            wb_wd_o    <= 32'd0;
        end else if (stall_i) begin
            wb_valid_o <= 1'b0;
            wb_we_o    <= 1'b0;
        end else begin
            wb_valid_o <= mem_valid_i;
            wb_we_o    <= mem_valid_i & mem_we_i;
            wb_wr_o    <= mem_wr_i;
            wb_wd_o    <= wb_select(mem_rf_wesl_i, mem_aluC_i,
                                    mem_pc4_i, ld_data_i);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: blocking data-memory access FSM (IDLE/BUSY/DONE)
// that freezes the front of the pipeline until dram_ack.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_rd2,
    input  logic [1:0]  mem_rf_wesl,
    input  logic [31:0] mem_pc4,
    input  logic [31:0] mem_aluC,
    input  logic        mem_dram_we,
    input  logic [4:0]  mem_wr,
    input  logic        mem_we,
    output logic        dram_req,
    output logic        dram_we,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    input  logic        dram_ack,
    input  logic [31:0] dram_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_wr,
    output logic [31:0] wb_wd
);

    mau_state_e  state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [31:0] rdata_q;
    logic        access;
    logic        busy;

    assign access = mem_valid &
                    (mem_dram_we | (mem_rf_wesl == WESL_LOAD));
    assign busy   = (state_q == ST_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: if (access) begin
                    addr_q  <= mem_aluC;
                    wdata_q <= mem_rd2;
                    we_q    <= mem_dram_we;
                    state_q <= ST_BUSY;
                end
                ST_BUSY: if (dram_ack) begin
                    rdata_q <= dram_rdata;
                    state_q <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // reset gates stall so a held access cannot freeze the pipe in reset
    assign stall = rst_n &
                   (((state_q == ST_IDLE) & access) | busy);

    assign dram_req   = busy;
    assign dram_we    = busy & we_q;
    assign dram_addr  = busy ? addr_q  : 32'd0;
    assign dram_wdata = busy ? wdata_q : 32'd0;

    mem_wb_reg u_mem_wb (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall),
        .mem_valid_i  (mem_valid),
        .mem_we_i     (mem_we),
        .mem_wr_i     (mem_wr),
        .mem_rf_wesl_i(mem_rf_wesl),
        .mem_aluC_i   (mem_aluC),
        .mem_pc4_i    (mem_pc4),
        .ld_data_i    (rdata_q),
        .wb_valid_o   (wb_valid),
        .wb_we_o      (wb_we),
        .wb_wr_o      (wb_wr),
        .wb_wd_o      (wb_wd)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed MEM-stage
// instructions with a bench-driven memory responder.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic [31:0] mem_rd2;
    logic [1:0]  mem_rf_wesl;
    logic [31:0] mem_pc4;
    logic [31:0] mem_aluC;
    logic        mem_dram_we;
    logic [4:0]  mem_wr;
    logic        mem_we;
    logic        dram_req;
    logic        dram_we;
    logic [31:0] dram_addr;
    logic [31:0] dram_wdata;
    logic        dram_ack;
    logic [31:0] dram_rdata;
    logic        stall;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_wr;
    logic [31:0] wb_wd;

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        we;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_valid  (mem_valid),
        .mem_rd2    (mem_rd2),
        .mem_rf_wesl(mem_rf_wesl),
        .mem_pc4    (mem_pc4),
        .mem_aluC   (mem_aluC),
        .mem_dram_we(mem_dram_we),
        .mem_wr     (mem_wr),
        .mem_we     (mem_we),
        .dram_req   (dram_req),
        .dram_we    (dram_we),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_ack   (dram_ack),
        .dram_rdata (dram_rdata),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_wr      (wb_wr),
        .wb_wd      (wb_wd)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every writeback must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected: got wr=%0d wd=%h",
                             wb_wr, wb_wd);
                end else begin
                    e = q.pop_front();
                    chk("wb_wr", {27'd0, wb_wr}, {27'd0, e.wr});
                    chk("wb_wd", wb_wd, e.wd);
                    chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                end
            end
        end
    end

    // Applies one instruction just after a posedge and holds it
    // while stalled; acks after nb BUSY cycles.
    task automatic issue(
        input  logic [1:0]  wesl,
        input  logic        dw,
        input  logic [31:0] alu,
        input  logic [31:0] pc4,
        input  logic [31:0] rd2,
        input  logic [4:0]  wr,
        input  logic        we,
        input  int          nb,
        input  logic [31:0] rdat,
        input  logic [31:0] exp_wd,
        output int          sc,
        output int          rc,
        output int          fr
    );
        bit   done = 0;
        logic s;
        q.push_back('{wr: wr, wd: exp_wd, we: we});
        mem_valid   = 1'b1;
        mem_rf_wesl = wesl;
        mem_dram_we = dw;
        mem_aluC    = alu;
        mem_pc4     = pc4;
        mem_rd2     = rd2;
        mem_wr      = wr;
        mem_we      = we;
        sc = 0;
        rc = 0;
        fr = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            s = stall;
            if (s) sc++;
            if (dram_req) begin
                rc++;
                if (fr < 0) fr = i;
                chk("dram_addr", dram_addr, alu);
                chk("dram_wdata", dram_wdata, rd2);
                chk("dram_we", {31'd0, dram_we}, {31'd0, dw});
                if (rc == nb) begin
                    dram_ack   = 1'b1;
                    dram_rdata = rdat;
                end
            end
            @(posedge clk);
            #1;
            dram_ack   = 1'b0;
            dram_rdata = 32'h0;
            if (!s) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: stall still %b", stall);
        end
        mem_valid = 1'b0;
    endtask

    initial begin
        int sc, rc, fr;
        rst_n       = 1'b0;
        mem_valid   = 1'b0;
        mem_rd2     = 32'h0;
        mem_rf_wesl = 2'b00;
        mem_pc4     = 32'h0;
        mem_aluC    = 32'h0;
        mem_dram_we = 1'b0;
        mem_wr      = 5'd0;
        mem_we      = 1'b0;
        dram_ack    = 1'b0;
        dram_rdata  = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dram_req", {31'd0, dram_req}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 0);
        chk("rst_wb_wd", wb_wd, 0);
        chk("rst_dram_addr", dram_addr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU op
        issue(2'b00, 0, 32'h1234, 32'h4, 32'h0, 5'd5, 1, 0,
              32'h0, 32'h1234, sc, rc, fr);
        chk("alu_stall_cycles", sc, 0);
        chk("alu_req_cycles", rc, 0);

        // load, ack on first BUSY cycle
        issue(2'b01, 0, 32'h100, 32'h8, 32'h0, 5'd7, 1, 1,
              32'hDEADBEEF, 32'hDEADBEEF, sc, rc, fr);
        chk("ld_stall_cycles", sc, 2);
        chk("ld_req_cycles", rc, 1);

        // store, ack after 4 BUSY cycles
        issue(2'b00, 1, 32'h200, 32'hC, 32'hCAFEF00D, 5'd3, 0, 4,
              32'h0, 32'h200, sc, rc, fr);
        chk("st_stall_cycles", sc, 5);
        chk("st_req_cycles", rc, 4);

        // back-to-back loads: one IDLE cycle before second req
        issue(2'b01, 0, 32'h300, 32'h10, 32'h0, 5'd8, 1, 2,
              32'h11112222, 32'h11112222, sc, rc, fr);
        chk("b2b0_first_req", fr, 1);
        chk("b2b0_stall_cycles", sc, 3);
        issue(2'b01, 0, 32'h304, 32'h14, 32'h0, 5'd9, 1, 1,
              32'h33334444, 32'h33334444, sc, rc, fr);
        chk("b2b1_first_req", fr, 1);
        chk("b2b1_stall_cycles", sc, 2);

        // reset in the middle of BUSY
        mem_valid   = 1'b1;
        mem_rf_wesl = 2'b01;
        mem_dram_we = 1'b0;
        mem_aluC    = 32'h400;
        mem_wr      = 5'd12;
        mem_we      = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_req", {31'd0, dram_req}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, dram_req}, 0);
        chk("mid_rst_stall", {31'd0, stall}, 0);
        chk("mid_rst_wb_valid", {31'd0, wb_valid}, 0);
        chk("mid_rst_addr", dram_addr, 0);
        mem_valid = 1'b0;
        dram_ack  = 1'b1;
        @(posedge clk);
        #1;
        dram_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(2'b00, 0, 32'h55, 32'h0, 32'h0, 5'd6, 1, 0,
              32'h0, 32'h55, sc, rc, fr);
        chk("post_rst_stall", sc, 0);

        // pc4 and alias ALU select
        issue(2'b10, 0, 32'h99, 32'h40, 32'h0, 5'd10, 1, 0,
              32'h0, 32'h40, sc, rc, fr);
        issue(2'b11, 0, 32'h7, 32'h44, 32'h0, 5'd11, 1, 0,
              32'h0, 32'h7, sc, rc, fr);

        // spurious ack while idle
        dram_ack   = 1'b1;
        dram_rdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        dram_ack   = 1'b0;
        dram_rdata = 32'h0;
        @(negedge clk);
        chk("spur_req", {31'd0, dram_req}, 0);
        chk("spur_stall", {31'd0, stall}, 0);
        chk("spur_wdata", dram_wdata, 0);
        @(posedge clk);
        #1;
        issue(2'b01, 0, 32'h500, 32'h0, 32'h0, 5'd13, 1, 1,
              32'h0A0B0C0D, 32'h0A0B0C0D, sc, rc, fr);
        chk("spur_ld_stall", sc, 2);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
